// File: rtl/bcd_stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch run-control slice.
package bcd_stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    LAP    = 2'd2,
    PAUSED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  localparam int TICK_DIV_DEFAULT = 50;
  localparam int TICK_W_DEFAULT   = 6;

  // Returns {carry, next_digit}; a digit never leaves 0..9.
  function automatic logic [4:0] bcd_inc(input logic [3:0] d);
    if (d == BCD_NINE) return {1'b1, BCD_ZERO};
    else               return {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter 00..99 with synchronous clear and a registered wrap pulse.
module bcd_digit_pair
  import bcd_stopwatch_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Clear,
  input  logic       E,
  output logic [3:0] Dig1,
  output logic [3:0] Dig0,
  output logic       Wrap
);

  logic [4:0] inc0;
  logic [4:0] inc1;

  assign inc0 = bcd_inc(Dig0);
  assign inc1 = bcd_inc(Dig1);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Dig1 <= BCD_ZERO;
      Dig0 <= BCD_ZERO;
      Wrap <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      if (Clear) begin
        Dig1 <= BCD_ZERO;
        Dig0 <= BCD_ZERO;
      end else if (E) begin
        Dig0 <= inc0[3:0];
        // Tens only moves on a units carry; a tens carry is the 99->00 wrap.
        if (inc0[4]) begin
          Dig1 <= inc1[3:0];
          Wrap <= inc1[4];
        end
      end
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch run control: button FSM, count-rate prescaler, lap hold and display mux.
module bcd_stopwatch_ctrl
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int TICK_W   = TICK_W_DEFAULT
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       StartStop,
  input  logic       LapReset,
  output logic       Run,
  output logic       Lapped,
  output logic       Wrap,
  output logic [3:0] Disp1,
  output logic [3:0] Disp0
);

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(TICK_DIV - 1);

  state_t            state;
  state_t            state_nxt;
  logic [TICK_W-1:0] presc;
  logic              running;
  logic              tick;
  logic              clear;
  logic              capture;
  logic [3:0]        cnt1;
  logic [3:0]        cnt0;
  logic [3:0]        hold1;
  logic [3:0]        hold0;

  assign running = (state == RUN) || (state == LAP);
  assign tick    = running && (presc == PRESC_LAST);

  // StartStop is tested first in every state so it wins over a coincident LapReset.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (StartStop) state_nxt = RUN;
      end
      RUN: begin
        if (StartStop) begin
          state_nxt = PAUSED;
        end else if (LapReset) begin
          state_nxt = LAP;
          capture   = 1'b1;
        end
      end
      LAP: begin
        if (StartStop)     state_nxt = PAUSED;
        else if (LapReset) state_nxt = RUN;
      end
      PAUSED: begin
        if (StartStop) begin
          state_nxt = RUN;
        end else if (LapReset) begin
          state_nxt = IDLE;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Prescaler freezes while paused so a resume finishes the interrupted interval.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (running) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + TICK_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hold1 <= BCD_ZERO;
      hold0 <= BCD_ZERO;
    end else if (capture) begin
      hold1 <= cnt1;
      hold0 <= cnt0;
    end
  end

  bcd_digit_pair u_count (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clear  (clear),
    .E      (tick),
    .Dig1   (cnt1),
    .Dig0   (cnt0),
    .Wrap   (Wrap)
  );

  assign Run    = running;
  assign Lapped = (state == LAP);
  assign Disp1  = Lapped ? hold1 : cnt1;
  assign Disp0  = Lapped ? hold0 : cnt0;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl against an arithmetic stopwatch model (TICK_DIV=4).
module tb_bcd_stopwatch_ctrl;

  localparam int TD = 4;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_LAP    = 2;
  localparam int S_PAUSED = 3;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       StartStop;
  logic       LapReset;
  logic       Run;
  logic       Lapped;
  logic       Wrap;
  logic [3:0] Disp1;
  logic [3:0] Disp0;

  typedef struct packed {
    logic       run;
    logic       lapped;
    logic       wrap;
    logic [3:0] d1;
    logic [3:0] d0;
  } exp_t;

  exp_t  q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string phase = "init";

  int m_st;
  int m_cnt;
  int m_presc;
  int m_hold;
  bit m_wrap;

  bcd_stopwatch_ctrl #(.TICK_DIV(TD), .TICK_W(3)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .StartStop (StartStop),
    .LapReset  (LapReset),
    .Run       (Run),
    .Lapped    (Lapped),
    .Wrap      (Wrap),
    .Disp1     (Disp1),
    .Disp0     (Disp0)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t model_out();
    exp_t o;
    int   show;
    o.run    = (m_st == S_RUN) || (m_st == S_LAP);
    o.lapped = (m_st == S_LAP);
    o.wrap   = m_wrap;
    show     = o.lapped ? m_hold : m_cnt;
    o.d1     = 4'(show / 10);
    o.d0     = 4'(show % 10);
    return o;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_presc = 0; m_hold = 0; m_wrap = 1'b0;
  endtask

  // One rising edge of the stopwatch, from the behavioural rules.
  task automatic model_step(input bit ss, input bit lr);
    int old_cnt;
    bit running;
    old_cnt = m_cnt;
    running = (m_st == S_RUN) || (m_st == S_LAP);
    m_wrap  = 1'b0;
    if (running && m_presc == TD - 1) begin
      m_cnt = (m_cnt + 1) % 100;
      m_wrap = (m_cnt == 0);
    end
    if (running) m_presc = (m_presc + 1) % TD;
    if (ss) begin
      case (m_st)
        S_IDLE:   m_st = S_RUN;
        S_RUN:    m_st = S_PAUSED;
        S_LAP:    m_st = S_PAUSED;
        default:  m_st = S_RUN;
      endcase
    end else if (lr) begin
      case (m_st)
        S_RUN:    begin m_hold = old_cnt; m_st = S_LAP; end
        S_LAP:    m_st = S_RUN;
        S_PAUSED: begin m_st = S_IDLE; m_cnt = 0; m_presc = 0; end
        default:  m_st = S_IDLE;
      endcase
    end
  endtask

  task automatic compare(input string name, input exp_t exp);
    exp_t act;
    act = {Run, Lapped, Wrap, Disp1, Disp0};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] t=%0t: got run=%0b lapped=%0b wrap=%0b disp=%0h%0h, expected run=%0b lapped=%0b wrap=%0b disp=%0h%0h",
               name, phase, $time, act.run, act.lapped, act.wrap, act.d1, act.d0,
               exp.run, exp.lapped, exp.wrap, exp.d1, exp.d0);
    end
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) compare("scoreboard", q.pop_front());
  end

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic cycle(input bit ss, input bit lr);
    StartStop = ss;
    LapReset  = lr;
    @(posedge Clock);
    #1;
    model_step(ss, lr);
    q.push_back(model_out());
    StartStop = 1'b0;
    LapReset  = 1'b0;
  endtask

  task automatic wait_count(input int target, input int presc_target);
    int guard = 0;
    while (!(m_cnt == target && (presc_target < 0 || m_presc == presc_target))) begin
      cycle(1'b0, 1'b0);
      guard++;
      if (guard > 2000) begin
        n_vec++;
        n_bad++;
        $display("FAIL wait_count [%s]: count %0d never reached, model at %0d", phase, target, m_cnt);
        break;
      end
    end
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic async_reset();
    #2;
    Resetn = 1'b0;
    #1;
    model_reset();
    compare("async_reset", model_out());
    q.delete();
    q.push_back(model_out());
    @(posedge Clock);
    #1;
    q.push_back(model_out());
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn    = 1'b0;
    StartStop = 1'b0;
    LapReset  = 1'b0;
    model_reset();
    #2;
    compare("reset_noclk", model_out());
    repeat (2) @(posedge Clock);
    #1;
    compare("reset", model_out());
    Resetn = 1'b1;

    phase = "start";
    cycle(1'b1, 1'b0);
    repeat (TD * 10) cycle(1'b0, 1'b0);

    phase = "wrap";
    wait_count(99, -1);
    repeat (TD * 2) cycle(1'b0, 1'b0);

    phase = "lap";
    wait_count(23, -1);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);

    phase = "pause";
    wait_count(37, 1);
    cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    phase = "simultaneous";
    cycle(1'b1, 1'b0);
    wait_count(5, -1);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    phase = "reset_in_lap";
    cycle(1'b1, 1'b0);
    wait_count(55, -1);
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    async_reset();
    repeat (10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      end
    end

    phase = "drain";
    repeat (2) @(posedge Clock);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
Run-control sequencer for a two-digit (00-99) BCD count datapath, used as a stopwatch/event timer front end.
- Converts debounced StartStop and LapReset button pulses into clear/enable sequencing of the count.
- Generates the count-rate tick from a clock prescaler.
- Provides a lap-hold display path.
- Sits between the button debouncers and the seven-segment decoders.

Parameters:
TICK_DIV, 50, clock cycles per count increment; legal range >= 1
TICK_W, 6, prescaler width; must satisfy 2^TICK_W >= TICK_DIV

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
StartStop  input  1  single-cycle synchronous pulse: start, pause or resume
LapReset  input  1  single-cycle synchronous pulse: lap toggle, or reset when paused
Run  output  1  high in RUN and LAP
Lapped  output  1  high in LAP (display frozen)
Wrap  output  1  one-cycle pulse when the count rolls 99->00
Disp1  output  4  tens digit to display (BCD)
Disp0  output  4  units digit to display (BCD)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (Resetn), Clock is the only clock.
  - While Resetn=0, without waiting for a clock edge: state=IDLE, count=00, prescaler=0, hold=00, Run=0, Lapped=0, Wrap=0, Disp=00.
  - A reset mid-count discards everything.
- FSM states: IDLE, RUN, LAP, PAUSED. Transitions are evaluated at the rising edge.
- IDLE:
  - StartStop -> RUN.
  - LapReset is ignored.
- RUN:
  - StartStop -> PAUSED.
  - LapReset -> LAP, capturing the current count into hold at the same edge.
- LAP:
  - The count keeps running.
  - LapReset -> RUN; display returns to live.
  - StartStop -> PAUSED; display returns to live.
- PAUSED:
  - StartStop -> RUN (resume).
  - LapReset -> IDLE with synchronous clear: count=00 and prescaler=0 at that edge.
- StartStop and LapReset in the same cycle: StartStop wins and LapReset is dropped, in every state.
- Prescaler:
  - Advances only in RUN or LAP, wrapping at TICK_DIV-1.
  - Holds its value in PAUSED, so a resume completes the partial interval.
  - Cleared only by reset or the PAUSED->IDLE clear.
- Count enable E = (state in RUN or LAP) and prescaler==TICK_DIV-1. The count advances at that edge.
- Start latency: StartStop sampled at edge k; Run=1 after edge k; first increment at edge k+TICK_DIV.
- TICK_DIV=1: E is high every RUN/LAP cycle.
- Count arithmetic:
  - Units digit goes 0..9; 9 -> 0 carries into tens.
  - 99 -> 00 wraps with no saturation and no halt; Run stays 1.
  - Digits never take values A-F.
- Wrap is registered: high for exactly the one cycle in which the count first reads 00 after a 99->00 increment. It is never asserted by a clear or by reset.
- Display: Disp = hold when Lapped=1, otherwise the live count. All outputs are registered or direct state decodes; no input-to-output combinational path.

Decomposition:
- Package bcd_stopwatch_pkg:
  - State enum {IDLE, RUN, LAP, PAUSED}.
  - BCD_NINE=4'd9 and BCD_ZERO constants.
  - Default TICK_DIV.
- One sub-module, bcd_digit_pair: the two-digit BCD count.
  - Inputs: Clock, Resetn, synchronous Clear, enable E.
  - Outputs: two digits and the Wrap pulse.
- bcd_stopwatch_ctrl holds the FSM, prescaler, hold register and display mux.

Test Plan:
All tests use TICK_DIV=4.
- Reset, then StartStop at edge 0 -> Run=1 after edge 0; Disp=01 after edge 4; Disp=10 after edge 40; Wrap stays 0.
- Run to Disp=99, then one more tick -> Disp=00; Wrap=1 for exactly one cycle; Run stays 1; next tick gives 01.
- LapReset at count 23 -> Lapped=1 and Disp holds 23. After 20 further cycles, LapReset -> Lapped=0 and Disp=28.
- Pause at 37 with prescaler=2, wait 10 cycles -> Disp stays 37. StartStop -> Disp=38 two edges later. StartStop, then LapReset -> Disp=00, Run=0, prescaler=0.
- Simultaneous StartStop+LapReset in RUN at count 05 -> PAUSED, Lapped=0, hold unchanged. LapReset alone in IDLE -> no state change.
- Drive Resetn low between edges at count 55 in LAP -> Disp=00, Run=0, Lapped=0 immediately. After release, the state stays IDLE until StartStop.
